reg_write_back: RTL and testbench

//  Write-back stage plus RV32I integer register file, directly downstream of the exec units.

---
 rtl/reg_write_back_pkg.sv | 47 ++++
 rtl/reg_write_back_if.sv | 38 +++
 rtl/reg_write_back_reg_file_array.sv | 40 ++++
 rtl/reg_write_back.sv | 62 ++++++
 tb/tb_reg_write_back.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/reg_write_back_pkg.sv
// ============================================================================
// reg_write_back_pkg : shared RV32I defs, WB entry type, forwarding read helper
// Rev 1.0
// ============================================================================
`default_nettype none

package reg_write_back_pkg;

  localparam int XLEN      = 32;
  localparam int REG_CNT   = 32;
  localparam int REG_IDX_W = 5;

  typedef logic [XLEN-1:0]      xlen_t;
  typedef logic [REG_IDX_W-1:0] ridx_t;

  localparam ridx_t REG_X0 = '0;

  // Major opcodes shared with decode/exec
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef struct packed {
    logic  pend;
    ridx_t idx;
    xlen_t val;
  } wb_entry_t;

  // x0 first, then the uncommitted WB entry, then the architectural array
  function automatic xlen_t fwd_read(input ridx_t idx, input wb_entry_t wb, input xlen_t arr_val);
    if (idx == REG_X0)
      return '0;
    else if (wb.pend && (wb.idx == idx))
      return wb.val;
    else
      return arr_val;
  endfunction

endpackage

`default_nettype wire

// File: rtl/reg_write_back_if.sv
// ============================================================================
// reg_write_back_if : exec-side write, operand read and debug/status bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface reg_write_back_if;
  import reg_write_back_pkg::*;

  logic        reg_w_op;
  ridx_t       reg_w_reg_idx;
  xlen_t       reg_w_reg_val;
  logic        wb_flush;
  ridx_t       reg_rs1;
  ridx_t       reg_rs2;
  xlen_t       reg_rs1_val;
  xlen_t       reg_rs2_val;
  ridx_t       dbg_idx;
  xlen_t       dbg_val;
  logic        wb_pending;
  ridx_t       wb_idx;
  logic [31:0] wr_cnt;

  modport master (
    output reg_w_op, reg_w_reg_idx, reg_w_reg_val, wb_flush,
    output reg_rs1, reg_rs2, dbg_idx,
    input  reg_rs1_val, reg_rs2_val, dbg_val, wb_pending, wb_idx, wr_cnt
  );

  modport slave (
    input  reg_w_op, reg_w_reg_idx, reg_w_reg_val, wb_flush,
    input  reg_rs1, reg_rs2, dbg_idx,
    output reg_rs1_val, reg_rs2_val, dbg_val, wb_pending, wb_idx, wr_cnt
  );

endinterface

`default_nettype wire

// File: rtl/reg_write_back_reg_file_array.sv
// ============================================================================
// reg_file_array : 32 x XLEN storage, one sync write, three async reads, x0 = 0
// Rev 1.0
// ============================================================================
`default_nettype none

module reg_file_array
  import reg_write_back_pkg::*;
(
  input  wire logic  clk,
  input  wire logic  rst,
  input  wire logic  we_i,
  input  wire ridx_t w_idx_i,
  input  wire xlen_t w_val_i,
  input  wire ridx_t rs1_idx_i,
  input  wire ridx_t rs2_idx_i,
  input  wire ridx_t dbg_idx_i,
  output xlen_t      rs1_val_o,
  output xlen_t      rs2_val_o,
  output xlen_t      dbg_val_o
);

  xlen_t mem_q [REG_CNT];

  // Entry 0 is cleared on reset and never written, so it stays zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_CNT; i++) mem_q[i] <= '0;
    end else if (we_i && (w_idx_i != REG_X0)) begin
      mem_q[w_idx_i] <= w_val_i;
    end
  end

  assign rs1_val_o = (rs1_idx_i == REG_X0) ? '0 : mem_q[rs1_idx_i];
  assign rs2_val_o = (rs2_idx_i == REG_X0) ? '0 : mem_q[rs2_idx_i];
  assign dbg_val_o = (dbg_idx_i == REG_X0) ? '0 : mem_q[dbg_idx_i];

endmodule

`default_nettype wire

// File: rtl/reg_write_back.sv
// ============================================================================
// reg_write_back : one-entry WB register, forwarding read muxes, commit counter
// Rev 1.0
// ============================================================================
`default_nettype none

module reg_write_back
  import reg_write_back_pkg::*;
(
  input  wire logic        clk,
  input  wire logic        rst,
  reg_write_back_if.slave  wbif
);

  wb_entry_t   wb_q, wb_d;
  logic [31:0] wr_cnt_q;
  xlen_t       arr_rs1, arr_rs2, arr_dbg;

  // Nothing from reg_w_* reaches the read ports in the same cycle; exec reads combinationally
  always_comb begin
    wb_d = '0;
    if (wbif.reg_w_op && !wbif.wb_flush && (wbif.reg_w_reg_idx != REG_X0)) begin
      wb_d.pend = 1'b1;
      wb_d.idx  = wbif.reg_w_reg_idx;
      wb_d.val  = wbif.reg_w_reg_val;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_q     <= '0;
      wr_cnt_q <= '0;
    end else begin
      wb_q <= wb_d;
      if (wb_q.pend) wr_cnt_q <= wr_cnt_q + 32'd1;
    end
  end

  reg_file_array u_array (
    .clk       (clk),
    .rst       (rst),
    .we_i      (wb_q.pend),
    .w_idx_i   (wb_q.idx),
    .w_val_i   (wb_q.val),
    .rs1_idx_i (wbif.reg_rs1),
    .rs2_idx_i (wbif.reg_rs2),
    .dbg_idx_i (wbif.dbg_idx),
    .rs1_val_o (arr_rs1),
    .rs2_val_o (arr_rs2),
    .dbg_val_o (arr_dbg)
  );

  assign wbif.reg_rs1_val = fwd_read(wbif.reg_rs1, wb_q, arr_rs1);
  assign wbif.reg_rs2_val = fwd_read(wbif.reg_rs2, wb_q, arr_rs2);
  assign wbif.dbg_val     = arr_dbg;
  assign wbif.wb_pending  = wb_q.pend;
  assign wbif.wb_idx      = wb_q.idx;
  assign wbif.wr_cnt      = wr_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_reg_write_back.sv
// ============================================================================
// tb_reg_write_back : directed vectors for the write-back stage / register file
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_reg_write_back;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  logic [31:0] exp_cnt = 0;

  reg_write_back_if wbif ();

  reg_write_back dut (
    .clk  (clk),
    .rst  (rst),
    .wbif (wbif.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_w(input logic op, input logic [4:0] idx, input logic [31:0] val, input logic fl);
    wbif.reg_w_op      = op;
    wbif.reg_w_reg_idx = idx;
    wbif.reg_w_reg_val = val;
    wbif.wb_flush      = fl;
  endtask

  task automatic rd(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d);
    wbif.reg_rs1 = r1;
    wbif.reg_rs2 = r2;
    wbif.dbg_idx = d;
    #1;
  endtask

  initial begin
    drive_w(1'b0, 5'd0, 32'h0, 1'b0);
    wbif.reg_rs1 = 5'd0;
    wbif.reg_rs2 = 5'd0;
    wbif.dbg_idx = 5'd0;
    #1 rst = 1'b1;
    #1;

    // 1: reset state
    for (int i = 0; i < 32; i++) begin
      rd(5'(i), 5'(31 - i), 5'(i));
      chk($sformatf("rst_rs1_x%0d", i), wbif.reg_rs1_val, 32'h0);
      chk($sformatf("rst_dbg_x%0d", i), wbif.dbg_val, 32'h0);
    end
    chk("rst_pending", 32'(wbif.wb_pending), 32'h0);
    chk("rst_wr_cnt", wbif.wr_cnt, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 2: x5 write, forward after one edge, array after two
    drive_w(1'b1, 5'd5, 32'h1234_5678, 1'b0);
    rd(5'd5, 5'd0, 5'd5);
    chk("x5_no_same_cycle_bypass", wbif.reg_rs1_val, 32'h0);
    @(negedge clk);
    drive_w(1'b0, 5'd0, 32'h0, 1'b0);
    rd(5'd5, 5'd5, 5'd5);
    chk("x5_fwd_rs1", wbif.reg_rs1_val, 32'h1234_5678);
    chk("x5_fwd_rs2", wbif.reg_rs2_val, 32'h1234_5678);
    chk("x5_pending", 32'(wbif.wb_pending), 32'h1);
    chk("x5_wb_idx", 32'(wbif.wb_idx), 32'd5);
    chk("x5_dbg_early", wbif.dbg_val, 32'h0);
    chk("x5_cnt_early", wbif.wr_cnt, exp_cnt);
    @(negedge clk);
    exp_cnt++;
    rd(5'd5, 5'd0, 5'd5);
    chk("x5_dbg_commit", wbif.dbg_val, 32'h1234_5678);
    chk("x5_rs1_array", wbif.reg_rs1_val, 32'h1234_5678);
    chk("x5_pending_clr", 32'(wbif.wb_pending), 32'h0);
    chk("x5_wb_idx_clr", 32'(wbif.wb_idx), 32'h0);
    chk("x5_wr_cnt", wbif.wr_cnt, exp_cnt);

    // 3: write to x0 is never captured
    drive_w(1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0);
    @(negedge clk);
    drive_w(1'b0, 5'd0, 32'h0, 1'b0);
    rd(5'd0, 5'd0, 5'd0);
    chk("x0_pending", 32'(wbif.wb_pending), 32'h0);
    chk("x0_rs1", wbif.reg_rs1_val, 32'h0);
    chk("x0_dbg", wbif.dbg_val, 32'h0);
    @(negedge clk);
    chk("x0_wr_cnt", wbif.wr_cnt, exp_cnt);

    // 4: back-to-back x7 = 1,2,3
    drive_w(1'b1, 5'd7, 32'd1, 1'b0);
    @(negedge clk);
    rd(5'd7, 5'd7, 5'd7);
    chk("b2b_fwd1", wbif.reg_rs1_val, 32'd1);
    chk("b2b_dbg0", wbif.dbg_val, 32'd0);
    drive_w(1'b1, 5'd7, 32'd2, 1'b0);
    @(negedge clk);
    exp_cnt++;
    rd(5'd7, 5'd7, 5'd7);
    chk("b2b_fwd2", wbif.reg_rs1_val, 32'd2);
    chk("b2b_fwd2_rs2", wbif.reg_rs2_val, 32'd2);
    chk("b2b_dbg1", wbif.dbg_val, 32'd1);
    chk("b2b_cnt1", wbif.wr_cnt, exp_cnt);
    drive_w(1'b1, 5'd7, 32'd3, 1'b0);
    @(negedge clk);
    exp_cnt++;
    drive_w(1'b0, 5'd0, 32'h0, 1'b0);
    rd(5'd7, 5'd5, 5'd7);
    chk("b2b_fwd3", wbif.reg_rs1_val, 32'd3);
    chk("b2b_rs2_x5", wbif.reg_rs2_val, 32'h1234_5678);
    chk("b2b_dbg2", wbif.dbg_val, 32'd2);
    @(negedge clk);
    exp_cnt++;
    rd(5'd7, 5'd0, 5'd7);
    chk("b2b_final", wbif.dbg_val, 32'd3);
    chk("b2b_wr_cnt", wbif.wr_cnt, exp_cnt);

    // 5: flush on the capture cycle drops the write
    drive_w(1'b1, 5'd9, 32'd5, 1'b1);
    @(negedge clk);
    drive_w(1'b0, 5'd0, 32'h0, 1'b0);
    rd(5'd9, 5'd0, 5'd9);
    chk("flush_pending", 32'(wbif.wb_pending), 32'h0);
    chk("flush_rs1", wbif.reg_rs1_val, 32'h0);
    @(negedge clk);
    chk("flush_dbg", wbif.dbg_val, 32'h0);
    chk("flush_cnt", wbif.wr_cnt, exp_cnt);
    // flush the cycle after a capture: the captured one still commits
    drive_w(1'b1, 5'd9, 32'd5, 1'b0);
    @(negedge clk);
    drive_w(1'b1, 5'd10, 32'h0000_00AA, 1'b1);
    @(negedge clk);
    exp_cnt++;
    drive_w(1'b0, 5'd0, 32'h0, 1'b0);
    rd(5'd9, 5'd9, 5'd9);
    chk("late_flush_dbg9", wbif.dbg_val, 32'd5);
    chk("rs1_eq_rs2_a", wbif.reg_rs1_val, 32'd5);
    chk("rs1_eq_rs2_b", wbif.reg_rs2_val, 32'd5);
    chk("late_flush_pending", 32'(wbif.wb_pending), 32'h0);
    chk("late_flush_cnt", wbif.wr_cnt, exp_cnt);
    @(negedge clk);
    rd(5'd10, 5'd0, 5'd10);
    chk("late_flush_x10", wbif.dbg_val, 32'h0);

    // 6: async reset mid-cycle with x3 pending
    drive_w(1'b1, 5'd3, 32'h0000_0033, 1'b0);
    @(negedge clk);
    drive_w(1'b0, 5'd0, 32'h0, 1'b0);
    rd(5'd3, 5'd9, 5'd7);
    chk("pre_rst_pending", 32'(wbif.wb_pending), 32'h1);
    chk("pre_rst_fwd3", wbif.reg_rs1_val, 32'h0000_0033);
    rst = 1'b1;
    #1;
    chk("async_rst_pending", 32'(wbif.wb_pending), 32'h0);
    chk("async_rst_wb_idx", 32'(wbif.wb_idx), 32'h0);
    chk("async_rst_cnt", wbif.wr_cnt, 32'h0);
    chk("async_rst_rs1_x3", wbif.reg_rs1_val, 32'h0);
    chk("async_rst_rs2_x9", wbif.reg_rs2_val, 32'h0);
    chk("async_rst_dbg_x7", wbif.dbg_val, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rd(5'd3, 5'd0, 5'd3);
    chk("post_rst_x3", wbif.reg_rs1_val, 32'h0);
    chk("post_rst_dbg_x3", wbif.dbg_val, 32'h0);
    chk("post_rst_cnt", wbif.wr_cnt, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
